branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL provide parameter INDEX_BITS, default 4, which sets the log2 of the branch history table (BHT) entry count.
REQ-002 SHALL provide parameter CNT_W, default 16, which sets the width of the misprediction statistics counter.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL provide port branch_id, input, 1, high when the instruction in ID is a conditional branch.
REQ-006 SHALL provide port pc_id, input, 32, PC of the instruction in ID.
REQ-007 SHALL provide port imm_id, input, 32, branch immediate of the ID instruction, in halfword units.
REQ-008 SHALL provide port stall, input, 1, high to hold the ID/EX prediction register.
REQ-009 SHALL provide port flush, input, 1, high to clear the ID/EX prediction register.
REQ-010 SHALL provide port branch_ex, input, 1, high when a branch resolves in EX this cycle.
REQ-011 SHALL provide port tobe_branch_flag, input, 1, actual outcome of the EX branch (1 = taken).
REQ-012 SHALL provide port pc_ex, input, 32, PC of the branch resolving in EX.
REQ-013 SHALL provide port predict_taken, output, 1, combinational taken prediction for the ID instruction.
REQ-014 SHALL provide port predicted_target, output, 32, combinational fetch redirect target for the ID instruction.
REQ-015 SHALL provide port prediction_ID_EX, output, 1, registered prediction travelling with the branch into EX.
REQ-016 SHALL provide port mispredict_count, output, CNT_W, saturating count of resolved mispredictions.

Function
REQ-017 SHALL hold 2**INDEX_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 SHALL index the BHT with pc[INDEX_BITS+1:2] for both lookup (pc_id) and update (pc_ex).
REQ-019 SHALL drive predict_taken = branch_id AND counter[idx_id][1], with zero latency (combinational).
REQ-020 SHALL drive predicted_target = pc_id + (imm_id << 1) when predict_taken = 1, and pc_id + 4 otherwise; both sums are 32-bit and wrap modulo 2**32.
REQ-021 SHALL load prediction_ID_EX with predict_taken on each clock edge where stall = 0 and flush = 0.
REQ-022 SHALL clear prediction_ID_EX to 0 on any clock edge where flush = 1; flush has priority over stall.
REQ-023 SHALL hold prediction_ID_EX unchanged on a clock edge where stall = 1 and flush = 0.
REQ-024 SHALL, when branch_ex = 1 and tobe_branch_flag = 1, increment counter[idx_ex] on the clock edge, saturating at 11.
REQ-025 SHALL, when branch_ex = 1 and tobe_branch_flag = 0, decrement counter[idx_ex] on the clock edge, saturating at 00.
REQ-026 SHALL leave every BHT counter unchanged on edges where branch_ex = 0; BHT updates are not gated by stall or flush.
REQ-027 SHALL, on a same-cycle lookup and update of one index, return the pre-update counter value; the new value is visible from the next cycle (no bypass).
REQ-028 SHALL increment mispredict_count by 1 on each edge where branch_ex = 1 and tobe_branch_flag != prediction_ID_EX.
REQ-029 SHALL saturate mispredict_count at all-ones and never wrap to 0.
REQ-030 SHALL show no X on any output once reset has been released, for any known-valued inputs.

Reset
REQ-031 SHALL, while reset = 0 and independent of clk, set every BHT counter to 01, prediction_ID_EX to 0, and mispredict_count to 0.
REQ-032 SHALL, when reset is asserted mid-operation, discard in-flight updates and predictions immediately; the first edge after release behaves as a fresh start.

Verification
REQ-033 SHALL verify default prediction: after reset, branch_id=1, pc_id=0x100, imm_id=0x10 -> predict_taken=0, predicted_target=0x104.
REQ-034 SHALL verify training: two taken updates at pc_ex=0x100 -> counter at 11; lookup at pc_id=0x100, imm_id=0x10 -> predict_taken=1, predicted_target=0x120; one not-taken update -> still taken; a second not-taken update -> predicts not taken.
REQ-035 SHALL verify aliasing and bypass: pc_ex=0x140 updates index 0 (INDEX_BITS=4), so it trains the same entry as pc_id=0x100; a same-cycle lookup returns the old value and the next cycle returns the new value.
REQ-036 SHALL verify stall and flush: stall=1 holds prediction_ID_EX=1 across 3 cycles; flush=1 together with stall=1 -> prediction_ID_EX=0 on the next edge.
REQ-037 SHALL verify statistics: prediction_ID_EX=0 with tobe_branch_flag=1 for 3 resolves -> mispredict_count=3; with CNT_W=4 and 20 mispredicts -> count holds at 15.
REQ-038 SHALL verify asynchronous reset: assert reset=0 between clock edges after training -> all outputs return to reset values before the next edge, and the lookup predicts not taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// a prediction register that follows the branch into EX, and a misprediction counter.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_id,
    input  logic [31:0]      pc_id,
    input  logic [31:0]      imm_id,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_ex,
    input  logic             tobe_branch_flag,
    input  logic [31:0]      pc_ex,
    output logic             predict_taken,
    output logic [31:0]      predicted_target,
    output logic             prediction_ID_EX,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            bht_q [ENTRIES];
    logic [1:0]            bht_d [ENTRIES];
    logic                  pred_q;
    logic                  pred_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [INDEX_BITS-1:0] idx_id;
    logic [INDEX_BITS-1:0] idx_ex;
    logic [1:0]            ctr_id;
    logic [1:0]            ctr_ex;
    logic                  pc_ex_unused;

    assign idx_id = pc_id[INDEX_BITS+1:2];
    assign idx_ex = pc_ex[INDEX_BITS+1:2];
    assign pc_ex_unused = ^{pc_ex[31:INDEX_BITS+2], pc_ex[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign ctr_id           = bht_q[idx_id];
    assign ctr_ex           = bht_q[idx_ex];
    assign predict_taken    = branch_id & ctr_id[1];
    assign predicted_target = predict_taken ? (pc_id + (imm_id << 1)) : (pc_id + 32'd4);
    assign prediction_ID_EX = pred_q;
    assign mispredict_count = cnt_q;

    always_comb begin
        bht_d = bht_q;
        if (branch_ex) begin
            if (tobe_branch_flag) begin
                if (ctr_ex != 2'b11) begin
                    bht_d[idx_ex] = ctr_ex + 2'd1;
                end
            end else if (ctr_ex != 2'b00) begin
                bht_d[idx_ex] = ctr_ex - 2'd1;
            end
        end
    end

    always_comb begin
        pred_d = pred_q;
        if (flush) begin
            pred_d = 1'b0;
        end else if (!stall) begin
            pred_d = predict_taken;
        end
    end

    // Compared against the prediction that travelled with this branch, not a fresh lookup.
    always_comb begin
        cnt_d = cnt_q;
        if (branch_ex && (tobe_branch_flag != pred_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            pred_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            bht_q  <= bht_d;
            pred_q <= pred_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes hand-computed expectations,
// a monitor pops and compares them at the falling edge or on an explicit sample event.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic        branch_id;
    logic [31:0] pc_id;
    logic [31:0] imm_id;
    logic        stall;
    logic        flush;
    logic        branch_ex;
    logic        tobe_branch_flag;
    logic [31:0] pc_ex;

    logic        predictTaken;
    logic [31:0] predictedTarget;
    logic        predictionIdEx;
    logic [15:0] mispredictCount;

    logic        predictTaken4;
    logic [31:0] predictedTarget4;
    logic        predictionIdEx4;
    logic [3:0]  mispredictCount4;

    typedef struct {
        string  name;
        longint pt;
        longint tgt;
        longint pid;
        longint cnt;
        longint cnt4;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared;
    int   nMismatched;
    event checkEv;

    branch_predictor #(.INDEX_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .branch_id(branch_id), .pc_id(pc_id), .imm_id(imm_id),
        .stall(stall), .flush(flush), .branch_ex(branch_ex),
        .tobe_branch_flag(tobe_branch_flag), .pc_ex(pc_ex),
        .predict_taken(predictTaken), .predicted_target(predictedTarget),
        .prediction_ID_EX(predictionIdEx), .mispredict_count(mispredictCount)
    );

    branch_predictor #(.INDEX_BITS(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .branch_id(branch_id), .pc_id(pc_id), .imm_id(imm_id),
        .stall(stall), .flush(flush), .branch_ex(branch_ex),
        .tobe_branch_flag(tobe_branch_flag), .pc_ex(pc_ex),
        .predict_taken(predictTaken4), .predicted_target(predictedTarget4),
        .prediction_ID_EX(predictionIdEx4), .mispredict_count(mispredictCount4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareField(input string name, input string field,
                                input longint act, input longint exp);
        if (exp < 0) return;
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, exp);
        end
    endtask

    // The monitor drains every queued expectation against the outputs as they stand now.
    always begin
        @(negedge clk or checkEv);
        while (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            compareField(e.name, "predict_taken", longint'(predictTaken), e.pt);
            compareField(e.name, "predicted_target", longint'(predictedTarget), e.tgt);
            compareField(e.name, "prediction_ID_EX", longint'(predictionIdEx), e.pid);
            compareField(e.name, "mispredict_count", longint'(mispredictCount), e.cnt);
            compareField(e.name, "mispredict_count_w4", longint'(mispredictCount4), e.cnt4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic bid, input logic [31:0] pcId, input logic [31:0] imm,
                                 input logic stl, input logic fls, input logic bex,
                                 input logic taken, input logic [31:0] pcEx);
        branch_id        = bid;
        pc_id            = pcId;
        imm_id           = imm;
        stall            = stl;
        flush            = fls;
        branch_ex        = bex;
        tobe_branch_flag = taken;
        pc_ex            = pcEx;
    endtask

    task automatic checkOutput(input string name, input longint pt, input longint tgt,
                               input longint pid, input longint cnt);
        exp_t e;
        e.name = name;
        e.pt   = pt;
        e.tgt  = tgt;
        e.pid  = pid;
        e.cnt  = cnt;
        e.cnt4 = (cnt > 15) ? 15 : cnt;
        sbQ.push_back(e);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        checkOutput("resetState", 0, 'h4, 0, 0);
        tick();
        reset = 1'b1;

        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("defaultPredict", 0, 'h104, 0, 0);
        tick();

        // Training entry 0 up to strong-taken, then back down.
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 1, 1, 32'h100);
        checkOutput("train1", 0, 'h104, 0, 0);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 1, 1, 32'h100);
        checkOutput("train2", 1, 'h120, 0, 1);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("strongTaken", 1, 'h120, 1, 2);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 1, 0, 32'h100);
        checkOutput("notTaken1", 1, 'h120, 1, 2);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("stillTaken", 1, 'h120, 1, 3);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 1, 0, 32'h100);
        checkOutput("notTaken2", 1, 'h120, 1, 3);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("nowNotTaken", 0, 'h104, 1, 4);
        tick();

        // 0x140 aliases to index 0; same-cycle lookup must see the old counter.
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 1, 1, 32'h140);
        checkOutput("aliasSameCycle", 0, 'h104, 0, 4);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("aliasNextCycle", 1, 'h120, 0, 5);
        tick();

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 32'h100, 32'h10, 1, 0, 0, 0, 32'h0);
            checkOutput($sformatf("stallHold%0d", k), 0, 'h104, 1, 5);
            tick();
        end
        applyStimulus(0, 32'h100, 32'h10, 1, 1, 0, 0, 32'h0);
        checkOutput("stallFlushBefore", 0, 'h104, 1, 5);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("flushOverStall", 1, 'h120, 0, 5);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 1, 0, 0, 32'h0);
        checkOutput("flushBefore", 1, 'h120, 1, 5);
        tick();
        applyStimulus(0, 32'h104, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("flushCleared", 0, 'h108, 0, 5);
        tick();

        // Reset asserted between edges while a taken update is pending.
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 1, 1, 32'h100);
        checkOutput("preResetLookup", 1, 'h120, 0, 5);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("asyncResetImmediate", 0, 'h104, 0, 0);
        ->checkEv;
        tick();
        checkOutput("resetHeldOverEdge", 0, 'h104, 0, 0);
        tick();
        reset = 1'b1;
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("freshStart", 0, 'h104, 0, 0);
        tick();

        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 32'h200, 32'h0, 0, 0, 1, 1, 32'h104);
            checkOutput($sformatf("mispredict%0d", k), 0, 'h204, 0, k);
            tick();
        end
        applyStimulus(1, 32'h104, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("otherIndexTrained", 1, 'h124, 0, 20);
        tick();
        applyStimulus(0, 32'hFFFF_FFFC, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("targetWrap", 0, 'h0, 1, 20);
        tick();
        applyStimulus(1, 32'h100, 32'h10, 0, 0, 0, 0, 32'h0);
        checkOutput("entry0AfterReset", 0, 'h104, 0, 20);
        tick();

        @(negedge clk);
        #1;
        if (sbQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL scoreboardDrain actual=%0d pending required=0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
